alu: RTL and testbench
======================

Name: alu

Overview:
- Parameterised integer ALU for the X09 CPU datapath.
- Computes one of 16 operations on operands A and B, with carry-in taken from the IFlags input.
- Result and flags are registered on the clock.
- Result drives the shared data bus through a tri-state output gated by OE.

Parameters:
- BitWidth, 8, width of the A, B and Y data paths (minimum 2).

Ports:
- Clock  input  1  system clock; rising-edge active.
- Reset_N  input  1  synchronous reset, active-low.
- A  input  BitWidth  operand A.
- B  input  BitWidth  operand B.
- FuncOp  input  4  operation select.
- IFlags  input  4  current flags; only IFlags[0] (C) is consumed, as carry-in.
- OE  input  1  output enable for Y.
- Y  output  BitWidth  registered result; high-Z when OE=0.
- OFlags  output  4  registered flags: [0]=C carry/borrow, [1]=Z zero, [2]=N negative (MSB), [3]=V signed overflow.

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset: on a rising Clock with Reset_N=0, the result register and the flag register clear to 0.
- Latency: 1 cycle. Operands and FuncOp are sampled on a rising edge; the result appears on Y/OFlags after that edge.
- Y = OE ? result_reg : all-Z. OE is purely combinational and has no effect on the registers. OFlags is always driven.
- Internally, form a BitWidth+1 sum so C comes from the extra bit. V = (A[msb]==Bop[msb]) && (R[msb]!=A[msb]), where Bop is the effective second operand (~B for subtract).
- Z = (R==0), N = R[msb]. This applies to every op that writes flags.
- FuncOp encoding:
  - 0 ADD: R=A+B; C=carry out; V signed overflow.
  - 1 ADC: R=A+B+IFlags[0]; C, V as ADD.
  - 2 SUB: R=A-B; C=1 on borrow (A<B unsigned); V=1 when the operand signs differ and the result sign differs from A.
  - 3 SBC: R=A-B-IFlags[0]; C, V as SUB.
  - 4 AND, 5 OR, 6 XOR: bitwise; C=0, V=0.
  - 7 NOT: R=~A; C=0, V=0.
  - 8 SHL: R=A<<1; C=A[msb]; V=0.
  - 9 SHR: logical right shift; C=A[0]; V=0.
  - A ASR: arithmetic right shift; C=A[0]; V=0.
  - B ROL: R={A[msb-1:0],C_in}; C=A[msb]; V=0.
  - C ROR: R={C_in,A[msb:1]}; C=A[0]; V=0.
  - D INC: R=A+1; C, V per ADD with B=1.
  - E DEC: R=A-1; C, V per SUB with B=1.
  - F CMP: flags computed as SUB; the result register holds its previous value.
- Wrap-around is modulo 2^BitWidth. Examples: 0xFF+0x01 → 0x00 with C=1, Z=1. 0x80-0x01 → 0x7F with V=1.
- A mid-operation reset wins over any FuncOp in the same cycle.

Optional Feature:
- Macro ALU_ROTATE_EN.
- When defined: ROL/ROR (FuncOp B, C) behave as specified above.
- When undefined: FuncOp B and C are NOPs. The result register and the flag register both hold their previous values. The rotate logic is not synthesised.

Test Plan:
- Reset: Reset_N=0 for 1 cycle, OE=1 → Y=0x00, OFlags=0000.
- ADD: A=0x7F, B=0x01, FuncOp=0 → next cycle Y=0x80, V=1, N=1, C=0, Z=0. Then A=0xFF, B=0x01 → Y=0x00, C=1, Z=1, V=0.
- SUB/SBC: A=0x05, B=0x07, FuncOp=2 → Y=0xFE, C=1 (borrow), N=1. Then A=0x80, B=0x01 → Y=0x7F, V=1. Then SBC with A=0x10, B=0x01, IFlags[0]=1 → Y=0x0E.
- CMP: FuncOp=F with A=B=0x42 → Z=1, C=0; Y unchanged from the prior result.
- Shift/rotate: A=0x81, FuncOp=8 → Y=0x02, C=1. ASR → Y=0xC0, C=1. ROL with IFlags[0]=0 → Y=0x02, C=1 with ALU_ROTATE_EN defined; without it, Y and flags unchanged.
- OE: any result with OE=0 → Y all-Z, OFlags still valid. Raise OE → the registered value appears the same cycle, no clock edge needed.

Source files
------------

// File: rtl/alu.sv
// Registered integer ALU: 16 ops, 1-cycle latency, Y tri-stated by OE; OFlags = {V,N,Z,C}.
// Rotates (FuncOp B/C) exist only with ALU_ROTATE_EN; otherwise they are NOPs that hold result and flags.
module alu #(
  parameter int BitWidth = 8
) (
  input  logic                Clock,
  input  logic                Reset_N,
  input  logic [BitWidth-1:0] A,
  input  logic [BitWidth-1:0] B,
  input  logic [3:0]          FuncOp,
  input  logic [3:0]          IFlags,
  input  logic                OE,
  output logic [BitWidth-1:0] Y,
  output logic [3:0]          OFlags
);

  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_ADC = 4'h1, OP_SUB = 4'h2, OP_SBC = 4'h3,
    OP_AND = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_NOT = 4'h7,
    OP_SHL = 4'h8, OP_SHR = 4'h9, OP_ASR = 4'hA, OP_ROL = 4'hB,
    OP_ROR = 4'hC, OP_INC = 4'hD, OP_DEC = 4'hE, OP_CMP = 4'hF
  } op_t;

  localparam logic [BitWidth-1:0] ONE = {{(BitWidth-1){1'b0}}, 1'b1};

  op_t                 op;
  logic                c_in;
  logic                unused_flags;
  logic [BitWidth-1:0] bop;
  logic                add_ci;
  logic                is_sub;
  logic [BitWidth:0]   sum;
  logic                arith_c;
  logic                arith_v;
  logic [BitWidth-1:0] r_nxt;
  logic                c_nxt;
  logic                v_nxt;
  logic                wr_res;
  logic                wr_flg;
  logic [BitWidth-1:0] res_q;
  logic [3:0]          flg_q;

  assign op           = op_t'(FuncOp);
  assign c_in         = IFlags[0];
  assign unused_flags = ^IFlags[3:1];

  // Subtracts run as A + ~B + 1 (or + ~C_in for SBC); borrow is the inverted carry-out.
  always_comb begin
    bop    = B;
    add_ci = 1'b0;
    is_sub = 1'b0;
    case (op)
      OP_ADC: add_ci = c_in;
      OP_SUB, OP_CMP: begin
        bop    = ~B;
        add_ci = 1'b1;
        is_sub = 1'b1;
      end
      OP_SBC: begin
        bop    = ~B;
        add_ci = ~c_in;
        is_sub = 1'b1;
      end
      OP_INC: bop = ONE;
      OP_DEC: begin
        bop    = ~ONE;
        add_ci = 1'b1;
        is_sub = 1'b1;
      end
      default: ;
    endcase
    sum     = {1'b0, A} + {1'b0, bop} + {{BitWidth{1'b0}}, add_ci};
    arith_c = is_sub ? ~sum[BitWidth] : sum[BitWidth];
    arith_v = (A[BitWidth-1] == bop[BitWidth-1]) && (sum[BitWidth-1] != A[BitWidth-1]);
  end

  always_comb begin
    r_nxt  = sum[BitWidth-1:0];
    c_nxt  = arith_c;
    v_nxt  = arith_v;
    wr_res = 1'b1;
    wr_flg = 1'b1;
    case (op)
      OP_AND: begin r_nxt = A & B; c_nxt = 1'b0; v_nxt = 1'b0; end
      OP_OR:  begin r_nxt = A | B; c_nxt = 1'b0; v_nxt = 1'b0; end
      OP_XOR: begin r_nxt = A ^ B; c_nxt = 1'b0; v_nxt = 1'b0; end
      OP_NOT: begin r_nxt = ~A;    c_nxt = 1'b0; v_nxt = 1'b0; end
      OP_SHL: begin r_nxt = {A[BitWidth-2:0], 1'b0};      c_nxt = A[BitWidth-1]; v_nxt = 1'b0; end
      OP_SHR: begin r_nxt = {1'b0, A[BitWidth-1:1]};      c_nxt = A[0];          v_nxt = 1'b0; end
      OP_ASR: begin r_nxt = {A[BitWidth-1], A[BitWidth-1:1]}; c_nxt = A[0];      v_nxt = 1'b0; end
`ifdef ALU_ROTATE_EN
      OP_ROL: begin r_nxt = {A[BitWidth-2:0], c_in};      c_nxt = A[BitWidth-1]; v_nxt = 1'b0; end
      OP_ROR: begin r_nxt = {c_in, A[BitWidth-1:1]};      c_nxt = A[0];          v_nxt = 1'b0; end
`else
      OP_ROL, OP_ROR: begin wr_res = 1'b0; wr_flg = 1'b0; end
`endif
      OP_CMP: wr_res = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset_N) begin
      res_q <= '0;
      flg_q <= '0;
    end else begin
      if (wr_res) res_q <= r_nxt;
      if (wr_flg) flg_q <= {v_nxt, r_nxt[BitWidth-1], (r_nxt == '0), c_nxt};
    end
  end

  assign Y      = OE ? res_q : {BitWidth{1'bz}};
  assign OFlags = flg_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu (BitWidth=8): table of vectors with a push/pop scoreboard, plus OE and reset sequences.
module tb_alu;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] a, b;
  logic [3:0]   op, iflags;
  logic         oe;
  wire  [W-1:0] y;
  logic [3:0]   oflags;

  always #5 clk = ~clk;

  alu #(.BitWidth(W)) dut (
    .Clock(clk), .Reset_N(rst_n), .A(a), .B(b), .FuncOp(op),
    .IFlags(iflags), .OE(oe), .Y(y), .OFlags(oflags)
  );

  typedef struct {
    string        name;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] ey;
    logic [3:0]   ef;
  } vec_t;

  typedef struct {
    string        name;
    logic [W-1:0] ey;
    logic [3:0]   ef;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(string n, logic [3:0] o, logic [W-1:0] va, logic [W-1:0] vb,
                              logic ci, logic [W-1:0] ey, logic [3:0] ef);
    vec_t v;
    v.name = n; v.op = o; v.a = va; v.b = vb; v.cin = ci; v.ey = ey; v.ef = ef;
    return v;
  endfunction

  task automatic check_y(string n, logic [W-1:0] exp);
    checks++;
    if (y !== exp) begin
      errors++;
      $display("FAIL %s Y got %h expected %h", n, y, exp);
    end
  endtask

  task automatic check_f(string n, logic [3:0] exp);
    checks++;
    if (oflags !== exp) begin
      errors++;
      $display("FAIL %s OFlags got %b expected %b", n, oflags, exp);
    end
  endtask

  // Drive one cycle of stimulus, record what should appear, then compare after the edge.
  task automatic apply(string n, logic r, logic [3:0] o, logic [W-1:0] va, logic [W-1:0] vb,
                       logic ci, logic [W-1:0] ey, logic [3:0] ef);
    exp_t e;
    rst_n  = r;
    op     = o;
    a      = va;
    b      = vb;
    iflags = {3'b000, ci};
    e.name = n; e.ey = ey; e.ef = ef;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_y(e.name, e.ey);
    check_f(e.name, e.ef);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Flags column is {V,N,Z,C}.
  initial begin
    vecs.push_back(mk("add_ovf",   4'h0, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b1100));
    vecs.push_back(mk("add_wrap",  4'h0, 8'hFF, 8'h01, 1'b0, 8'h00, 4'b0011));
    vecs.push_back(mk("adc_cin",   4'h1, 8'h10, 8'h20, 1'b1, 8'h31, 4'b0000));
    vecs.push_back(mk("sub_borrow",4'h2, 8'h05, 8'h07, 1'b0, 8'hFE, 4'b0101));
    vecs.push_back(mk("sub_ovf",   4'h2, 8'h80, 8'h01, 1'b0, 8'h7F, 4'b1000));
    vecs.push_back(mk("sbc_cin",   4'h3, 8'h10, 8'h01, 1'b1, 8'h0E, 4'b0000));
    vecs.push_back(mk("cmp_eq",    4'hF, 8'h42, 8'h42, 1'b0, 8'h0E, 4'b0010));
    vecs.push_back(mk("and",       4'h4, 8'hF0, 8'h3C, 1'b1, 8'h30, 4'b0000));
    vecs.push_back(mk("or",        4'h5, 8'h0F, 8'hF0, 1'b0, 8'hFF, 4'b0100));
    vecs.push_back(mk("xor_zero",  4'h6, 8'hAA, 8'hAA, 1'b0, 8'h00, 4'b0010));
    vecs.push_back(mk("not",       4'h7, 8'h0F, 8'h00, 1'b0, 8'hF0, 4'b0100));
    vecs.push_back(mk("shl",       4'h8, 8'h81, 8'h00, 1'b0, 8'h02, 4'b0001));
    vecs.push_back(mk("shr",       4'h9, 8'h81, 8'h00, 1'b0, 8'h40, 4'b0001));
    vecs.push_back(mk("asr",       4'hA, 8'h81, 8'h00, 1'b0, 8'hC0, 4'b0101));
`ifdef ALU_ROTATE_EN
    vecs.push_back(mk("rol",       4'hB, 8'h81, 8'h00, 1'b0, 8'h02, 4'b0001));
    vecs.push_back(mk("ror",       4'hC, 8'h01, 8'h00, 1'b1, 8'h80, 4'b0101));
`else
    vecs.push_back(mk("rol_nop",   4'hB, 8'h81, 8'h00, 1'b0, 8'hC0, 4'b0101));
    vecs.push_back(mk("ror_nop",   4'hC, 8'h01, 8'h00, 1'b1, 8'hC0, 4'b0101));
`endif
    vecs.push_back(mk("inc_wrap",  4'hD, 8'hFF, 8'h00, 1'b0, 8'h00, 4'b0011));
    vecs.push_back(mk("dec_borrow",4'hE, 8'h00, 8'h00, 1'b0, 8'hFF, 4'b0101));
    vecs.push_back(mk("dec_ovf",   4'hE, 8'h80, 8'h00, 1'b0, 8'h7F, 4'b1000));
    vecs.push_back(mk("inc_ovf",   4'hD, 8'h7F, 8'h00, 1'b1, 8'h80, 4'b1100));
    vecs.push_back(mk("sbc_borrow",4'h3, 8'h00, 8'h00, 1'b1, 8'hFF, 4'b0101));
    vecs.push_back(mk("adc_wrap",  4'h1, 8'hFF, 8'h00, 1'b1, 8'h00, 4'b0011));

    rst_n = 1'b0; op = 4'h0; a = '0; b = '0; iflags = '0; oe = 1'b1;
    @(posedge clk);
    #1;
    apply("reset", 1'b0, 4'h0, 8'h12, 8'h34, 1'b0, 8'h00, 4'b0000);

    foreach (vecs[i])
      apply(vecs[i].name, 1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin,
            vecs[i].ey, vecs[i].ef);

    // OE gates only the bus; a 2-state simulator may read a released bus as 0.
    apply("oe_setup", 1'b1, 4'h0, 8'h12, 8'h34, 1'b0, 8'h46, 4'b0000);
    oe = 1'b0;
    #1;
    checks++;
    if (!((y === 8'hzz) || (y === 8'h00))) begin
      errors++;
      $display("FAIL oe_low Y got %h expected zz", y);
    end
    check_f("oe_low_flags", 4'b0000);
    apply("oe_low_op", 1'b1, 4'h0, 8'h7F, 8'h7F, 1'b0, 8'h00, 4'b1100);
    oe = 1'b1;
    #1;
    check_y("oe_raise", 8'hFE);

    apply("reset_mid_op", 1'b0, 4'h0, 8'h7F, 8'h01, 1'b0, 8'h00, 4'b0000);
    apply("after_reset", 1'b1, 4'h5, 8'h01, 8'h02, 1'b0, 8'h03, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
